// File: rtl/my_mcu_avalon_master.sv
// ---------------------------------------------------------------------------
// my_mcu_avalon_master
//
// Bridges a simple valid/ready command/response interface onto an Avalon-MM
// master port with active-low read/write strobes. Only one transfer is in
// flight at a time. Commands are accepted in IDLE and driven on the bus in
// BUS. The result is held in RESP until the controller takes it. A stalled
// slave is abandoned after TIMEOUT wait-request cycles.
//
// Ports
//   clk, reset            : clock; synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_write             : 1 = write, 0 = read
//   cmd_address           : word address (ADDR_W bits)
//   cmd_writedata         : write payload (32 bits)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_readdata          : read data (0 for writes and timeouts)
//   rsp_error             : 1 = transfer abandoned by timeout
//   avm_*                 : Avalon-MM master signals (zero read latency)
// ---------------------------------------------------------------------------
module my_mcu_avalon_master #(
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_error_q, rsp_error_d;
    logic [31:0]         rsp_readdata_q, rsp_readdata_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic                avm_chipselect_q, avm_chipselect_d;
    logic                avm_write_n_q, avm_write_n_d;
    logic                avm_read_n_q, avm_read_n_d;
    logic [31:0]         avm_writedata_q, avm_writedata_d;

    always_comb begin
        state_d          = state_q;
        wr_d             = wr_q;
        cnt_d            = cnt_q;
        cmd_ready_d      = cmd_ready_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_error_d      = rsp_error_q;
        rsp_readdata_d   = rsp_readdata_q;
        avm_address_d    = avm_address_q;
        avm_chipselect_d = avm_chipselect_q;
        avm_write_n_d    = avm_write_n_q;
        avm_read_n_d     = avm_read_n_q;
        avm_writedata_d  = avm_writedata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d          = BUS;
                    wr_d             = cmd_write;
                    cnt_d            = 16'd0;
                    cmd_ready_d      = 1'b0;
                    avm_address_d    = cmd_address;
                    avm_writedata_d  = cmd_writedata;
                    avm_chipselect_d = 1'b1;
                    avm_write_n_d    = ~cmd_write;
                    avm_read_n_d     = cmd_write;
                end
            end
            BUS: begin
                // A slave releasing waitrequest on the very cycle the counter
                // hits the limit still completes normally: waitrequest wins.
                if (!avm_waitrequest || (cnt_q == TIMEOUT_CNT)) begin
                    state_d          = RESP;
                    rsp_valid_d      = 1'b1;
                    rsp_error_d      = avm_waitrequest;
                    rsp_readdata_d   = (wr_q || avm_waitrequest) ? 32'd0 : avm_readdata;
                    avm_chipselect_d = 1'b0;
                    avm_write_n_d    = 1'b1;
                    avm_read_n_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d        = IDLE;
                    rsp_valid_d    = 1'b0;
                    rsp_error_d    = 1'b0;
                    rsp_readdata_d = 32'd0;
                    cmd_ready_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            wr_q             <= 1'b0;
            cnt_q            <= 16'd0;
            cmd_ready_q      <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_error_q      <= 1'b0;
            rsp_readdata_q   <= 32'd0;
            avm_address_q    <= '0;
            avm_chipselect_q <= 1'b0;
            avm_write_n_q    <= 1'b1;
            avm_read_n_q     <= 1'b1;
            avm_writedata_q  <= 32'd0;
        end else begin
            state_q          <= state_d;
            wr_q             <= wr_d;
            cnt_q            <= cnt_d;
            cmd_ready_q      <= cmd_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_error_q      <= rsp_error_d;
            rsp_readdata_q   <= rsp_readdata_d;
            avm_address_q    <= avm_address_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_write_n_q    <= avm_write_n_d;
            avm_read_n_q     <= avm_read_n_d;
            avm_writedata_q  <= avm_writedata_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_error      = rsp_error_q;
    assign rsp_readdata   = rsp_readdata_q;
    assign avm_address    = avm_address_q;
    assign avm_chipselect = avm_chipselect_q;
    assign avm_write_n    = avm_write_n_q;
    assign avm_read_n     = avm_read_n_q;
    assign avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_my_mcu_avalon_master.sv
module tb_my_mcu_avalon_master;

    localparam int MAIN_T = 8;
    localparam int T4     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_write;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_ready;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    logic        cmd_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_readdata, avm_writedata;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n, avm_read_n;

    logic        t4_cmd_ready, t4_rsp_valid, t4_rsp_error;
    logic [31:0] t4_rsp_readdata, t4_avm_writedata;
    logic [1:0]  t4_avm_address;
    logic        t4_avm_chipselect, t4_avm_write_n, t4_avm_read_n;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] slave_mem [4];
    logic [31:0] ref_mem   [4];

    always #5 clk = ~clk;

    my_mcu_avalon_master #(.ADDR_W(2), .TIMEOUT(MAIN_T)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    my_mcu_avalon_master #(.ADDR_W(2), .TIMEOUT(T4)) dut_t4 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(t4_cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .rsp_valid(t4_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_readdata(t4_rsp_readdata), .rsp_error(t4_rsp_error),
        .avm_address(t4_avm_address), .avm_chipselect(t4_avm_chipselect),
        .avm_write_n(t4_avm_write_n), .avm_read_n(t4_avm_read_n),
        .avm_writedata(t4_avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    // Zero-latency PIO-like slave attached to the main instance.
    assign avm_readdata = slave_mem[avm_address];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) slave_mem[i] <= 32'd0;
        end else if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
            slave_mem[avm_address] <= avm_writedata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic noise_cmd();
        cmd_valid     = 1'b1;
        cmd_write     = 1'($urandom);
        cmd_address   = 2'($urandom);
        cmd_writedata = $urandom;
    endtask

    // One complete transfer starting from IDLE at a negedge. exp_rd/exp_err
    // are for the main instance; the TIMEOUT=4 instance is modelled here.
    task automatic xfer(input logic wr, input logic [1:0] addr, input logic [31:0] data,
                        input int stall, input int rdy,
                        input logic [31:0] exp_rd, input logic exp_err);
        int          e, e4;
        logic        err4;
        logic [31:0] rd4;
        e    = (stall <= MAIN_T) ? stall + 1 : MAIN_T + 1;
        e4   = (stall <= T4) ? stall + 1 : T4 + 1;
        err4 = (stall > T4);
        rd4  = (wr || err4) ? 32'd0 : ref_mem[addr];

        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_writedata = data;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < e; k++) begin
            chk("bus_strobes", {29'd0, avm_chipselect, avm_write_n, avm_read_n},
                {29'd0, 1'b1, ~wr, wr});
            chk("bus_addr", {30'd0, avm_address}, {30'd0, addr});
            chk("bus_wdata", avm_writedata, data);
            chk("bus_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("t4_bus_cs", {31'd0, t4_avm_chipselect}, {31'd0, (k < e4)});
            noise_cmd();
            avm_waitrequest = (k < stall);
            @(posedge clk); @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
        chk("rsp_readdata", rsp_readdata, exp_rd);
        chk("rel_strobes", {29'd0, avm_chipselect, avm_write_n, avm_read_n}, 32'b011);
        chk("rel_addr", {30'd0, avm_address}, {30'd0, addr});
        chk("t4_rsp_valid", {31'd0, t4_rsp_valid}, 32'd1);
        chk("t4_rsp_error", {31'd0, t4_rsp_error}, {31'd0, err4});
        chk("t4_rsp_readdata", t4_rsp_readdata, rd4);
        for (int r = 0; r < rdy; r++) begin
            noise_cmd();
            @(posedge clk); @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_readdata, exp_rd);
            chk("hold_err", {31'd0, rsp_error}, {31'd0, exp_err});
            chk("hold_no_bus", {29'd0, avm_chipselect, avm_write_n, avm_read_n}, 32'b011);
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("done_no_bus", {31'd0, avm_chipselect}, 32'd0);
        chk("t4_done_valid", {31'd0, t4_rsp_valid}, 32'd0);
        if (wr && stall <= MAIN_T) ref_mem[addr] = data;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        int          stall;
        int          rdy;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 32'h0000A5C3, 0, 0, 32'h0,          1'b0};
        vecs[1]  = '{1'b0, 2'd0, 32'h11111111, 0, 0, 32'h0000A5C3,   1'b0};
        vecs[2]  = '{1'b0, 2'd1, 32'h22222222, 0, 1, 32'h0,          1'b0};
        vecs[3]  = '{1'b1, 2'd2, 32'h12345678, 0, 0, 32'h0,          1'b0};
        vecs[4]  = '{1'b0, 2'd2, 32'h0,        5, 0, 32'h12345678,   1'b0};
        vecs[5]  = '{1'b0, 2'd0, 32'h0,        4, 0, 32'h0000A5C3,   1'b0};
        vecs[6]  = '{1'b0, 2'd2, 32'h0,        8, 2, 32'h12345678,   1'b0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,        9, 0, 32'h0,          1'b1};
        vecs[8]  = '{1'b1, 2'd3, 32'hDEADBEEF, 9, 0, 32'h0,          1'b1};
        vecs[9]  = '{1'b0, 2'd3, 32'h0,        0, 0, 32'h0,          1'b0};
        vecs[10] = '{1'b0, 2'd0, 32'h0,        0, 10, 32'h0000A5C3,  1'b0};

        for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 2'd0;
        cmd_writedata = 32'd0; rsp_ready = 1'b0; avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_rsp_readdata", rsp_readdata, 32'd0);
        chk("rst_strobes", {29'd0, avm_chipselect, avm_write_n, avm_read_n}, 32'b011);
        chk("rst_addr", {30'd0, avm_address}, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);

        for (int i = 0; i < 11; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].rdy,
                 vecs[i].exp_rd, vecs[i].exp_err);
            if (i == 0) chk("pio_out_port", slave_mem[0], 32'h0000A5C3);
        end
        chk("timed_out_write_absent", slave_mem[3], 32'd0);

        // Reset while the slave is stalling the bus
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd2; cmd_writedata = 32'd0;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; avm_waitrequest = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("pre_reset_cs", {31'd0, avm_chipselect}, 32'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; avm_waitrequest = 1'b0;
        chk("mid_rst_strobes", {29'd0, avm_chipselect, avm_write_n, avm_read_n}, 32'b011);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_t4_cs", {31'd0, t4_avm_chipselect}, 32'd0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Slave memory was cleared by that reset; restart the model from zero.
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;

        // Randomised transfers against the transaction-level model
        for (int n = 0; n < 60; n++) begin
            logic        wr;
            logic [1:0]  addr;
            logic [31:0] data, exp_rd;
            int          stall;
            logic        exp_err;
            wr      = 1'($urandom);
            addr    = 2'($urandom);
            data    = $urandom;
            stall   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : $urandom_range(0, 2);
            exp_err = (stall > MAIN_T);
            exp_rd  = (wr || exp_err) ? 32'd0 : ref_mem[addr];
            xfer(wr, addr, data, stall, $urandom_range(0, 3), exp_rd, exp_err);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
        end
        for (int i = 0; i < 4; i++) chk("final_mem", slave_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
